sw_debounce: RTL and testbench

//  Conditions raw DE2 slide-switch inputs before they reach LED/decode logic.
//  - Each bit passes through a 2-flop synchronizer, then a per-bit debounce counter.
//  - Outputs: clean switch levels, 1-cycle rise/fall pulses and a per-bit toggle latch.
//  - Sits directly upstream of the switch-to-LED combinational stage; its sw output

---
 rtl/sw_debounce.sv | 98 +++++++++
 tb/tb_sw_debounce.sv | 136 +++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// Slide-switch conditioner: a 2-flop synchronizer and a per-bit debounce FSM that
// produces clean levels, one-cycle rise/fall pulses and a toggle latch.
module sw_debounce #(
    parameter int WIDTH     = 2,
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic [WIDTH-1:0] sw_tog
);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw_raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        state_e           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             sw_q;
        logic             rise_q;
        logic             fall_q;
        logic             tog_q;

        assign cnt_d = cnt_q + CNT_W'(1);

        // Pulses default low every cycle so they last exactly one cycle after acceptance.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q <= ST_STABLE;
                cnt_q   <= '0;
                sw_q    <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
                tog_q   <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                case (state_q)
                    ST_STABLE: begin
                        if (sync2_q[gi] != sw_q) begin
                            state_q <= ST_COUNT;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                    ST_COUNT: begin
                        if (sync2_q[gi] == sw_q) begin
                            state_q <= ST_STABLE;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_MAX) begin
                            state_q <= ST_STABLE;
                            cnt_q   <= '0;
                            sw_q    <= sync2_q[gi];
                            rise_q  <= sync2_q[gi];
                            fall_q  <= ~sync2_q[gi];
                            if (sync2_q[gi]) begin
                                tog_q <= ~tog_q;
                            end
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    default: begin
                        state_q <= ST_STABLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end

        assign sw[gi]      = sw_q;
        assign sw_rise[gi] = rise_q;
        assign sw_fall[gi] = fall_q;
        assign sw_tog[gi]  = tog_q;
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce (DB_CYCLES=4): stimulus pushes per-cycle expected
// outputs into a queue, a monitor pops and compares after each rising edge.
module tb_sw_debounce;

    localparam int WIDTH = 2;

    typedef struct packed {
        logic [1:0] sw;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] tog;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] sw_raw = '0;
    logic [WIDTH-1:0] sw;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic [WIDTH-1:0] sw_tog;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_vec = 0;
    int    n_bad = 0;
    string cur_tag = "init";

    sw_debounce #(
        .WIDTH    (WIDTH),
        .DB_CYCLES(4),
        .CNT_W    (20)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sw_raw (sw_raw),
        .sw     (sw),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall),
        .sw_tog (sw_tog)
    );

    always #5 clk = ~clk;

    // One vector: inputs presented before the next rising edge, outputs expected after it.
    task automatic step(input logic r, input logic [1:0] raw, input logic [1:0] e_sw,
                        input logic [1:0] e_rise, input logic [1:0] e_fall,
                        input logic [1:0] e_tog);
        exp_t e;
        @(negedge clk);
        rst_n  = r;
        sw_raw = raw;
        e.sw   = e_sw;
        e.rise = e_rise;
        e.fall = e_fall;
        e.tog  = e_tog;
        exp_q.push_back(e);
        tag_q.push_back(cur_tag);
    endtask

    // Hold raw steady through a full accept: 5 edges unchanged, change on the 6th, 2 quiet edges.
    task automatic settle(input logic [1:0] raw, input logic [1:0] old_sw,
                          input logic [1:0] old_tog, input logic [1:0] new_sw,
                          input logic [1:0] rise, input logic [1:0] fall,
                          input logic [1:0] new_tog);
        for (int i = 0; i < 5; i++) step(1'b1, raw, old_sw, 2'b00, 2'b00, old_tog);
        step(1'b1, raw, new_sw, rise, fall, new_tog);
        for (int i = 0; i < 2; i++) step(1'b1, raw, new_sw, 2'b00, 2'b00, new_tog);
    endtask

    always @(posedge clk) begin
        exp_t  e;
        string t;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_vec++;
            if (sw !== e.sw || sw_rise !== e.rise || sw_fall !== e.fall || sw_tog !== e.tog) begin
                n_bad++;
                $display("FAIL %s vec%0d: got sw=%b rise=%b fall=%b tog=%b, want sw=%b rise=%b fall=%b tog=%b",
                         t, n_vec, sw, sw_rise, sw_fall, sw_tog, e.sw, e.rise, e.fall, e.tog);
            end
        end
    end

    initial begin
        // 1: reset with switches already high, then power-up acceptance
        cur_tag = "reset";
        for (int i = 0; i < 2; i++) step(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        cur_tag = "powerup";
        settle(2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b11);

        // 2: bit0 down then clean press
        cur_tag = "prep_low0";
        settle(2'b10, 2'b11, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11);
        cur_tag = "press0";
        settle(2'b11, 2'b10, 2'b11, 2'b11, 2'b01, 2'b00, 2'b10);

        // 3: bit0 down, then bounce that never holds long enough
        cur_tag = "prep_low0b";
        settle(2'b10, 2'b11, 2'b10, 2'b10, 2'b00, 2'b01, 2'b10);
        cur_tag = "bounce";
        for (int i = 0; i < 3; i++) step(1'b1, 2'b11, 2'b10, 2'b00, 2'b00, 2'b10);
        step(1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10);
        for (int i = 0; i < 2; i++) step(1'b1, 2'b11, 2'b10, 2'b00, 2'b00, 2'b10);
        for (int i = 0; i < 8; i++) step(1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10);

        // 4: bit1 release, toggle must not change
        cur_tag = "release1";
        settle(2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 2'b10);

        // 5: both bits rise together
        cur_tag = "simul";
        settle(2'b11, 2'b00, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01);

        // 6: both down, then reset during a count on bit0
        cur_tag = "both_low";
        settle(2'b00, 2'b11, 2'b01, 2'b00, 2'b00, 2'b11, 2'b01);
        cur_tag = "midcount";
        for (int i = 0; i < 4; i++) step(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
        cur_tag = "mid_reset";
        for (int i = 0; i < 2; i++) step(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        cur_tag = "restart";
        settle(2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01);

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected vectors left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
